debounce_multi: RTL and testbench

//   N-channel button debouncer/edge detector, parametrised successor of the single-channel debounce.

---
 rtl/debounce_multi.sv | 122 ++++++++++++
 tb/tb_debounce_multi.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/debounce_multi.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_multi
//  Description : N-channel button debouncer with a tick-paced stability
//                counter, rise/fall pulses and optional auto-repeat press.
//  Revision    : 1.0 - initial release
// ============================================================================
module debounce_multi #(
    parameter int N            = 4,
    parameter int STABLE_TICKS = 4,
    parameter int REPEAT_EN    = 1,
    parameter int HOLD_TICKS   = 10,
    parameter int REPEAT_TICKS = 3
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         tick,
    input  logic [N-1:0] in,
    output logic [N-1:0] level,
    output logic [N-1:0] rise,
    output logic [N-1:0] fall,
    output logic [N-1:0] press
);

    localparam int CW   = $clog2(STABLE_TICKS) + 1;
    localparam int HMAX = (HOLD_TICKS > REPEAT_TICKS) ? HOLD_TICKS : REPEAT_TICKS;
    localparam int HW   = $clog2(HMAX) + 1;

    localparam logic [CW-1:0] C_CNT_LAST = CW'(STABLE_TICKS - 1);
    localparam logic [HW-1:0] C_HOLD     = HW'(HOLD_TICKS);
    localparam logic [HW-1:0] C_RPT      = HW'(REPEAT_TICKS);

    logic [N-1:0]  sync1_q, sync2_q;
    logic [CW-1:0] cnt_q  [N];
    logic [CW-1:0] cnt_d  [N];
    logic [HW-1:0] hcnt_q [N];
    logic [HW-1:0] hcnt_d [N];
    logic [N-1:0]  phase_q, phase_d;
    logic [N-1:0]  level_q, level_d;
    logic [N-1:0]  rise_q, rise_d;
    logic [N-1:0]  fall_q, fall_d;
    logic [N-1:0]  press_q, press_d;

    always_comb begin
        cnt_d   = cnt_q;
        hcnt_d  = hcnt_q;
        phase_d = phase_q;
        level_d = level_q;
        rise_d  = '0;
        fall_d  = '0;
        press_d = '0;
        for (int i = 0; i < N; i++) begin
            if (tick) begin
                if (sync2_q[i] == level_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] < C_CNT_LAST) begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end else begin
                    level_d[i] = sync2_q[i];
                    cnt_d[i]   = '0;
                    rise_d[i]  = sync2_q[i];
                    fall_d[i]  = ~sync2_q[i];
                end

                // Hold counter restarts on every press; phase selects the
                // initial hold delay versus the shorter repeat interval.
                if (rise_d[i]) begin
                    hcnt_d[i]  = '0;
                    phase_d[i] = 1'b0;
                    press_d[i] = 1'b1;
                end else if (fall_d[i] || !level_q[i]) begin
                    hcnt_d[i]  = '0;
                    phase_d[i] = 1'b0;
                end else if ((hcnt_q[i] + HW'(1)) == (phase_q[i] ? C_RPT : C_HOLD)) begin
                    hcnt_d[i]  = '0;
                    phase_d[i] = 1'b1;
                    press_d[i] = 1'b1;
                end else begin
                    hcnt_d[i]  = hcnt_q[i] + HW'(1);
                end
            end
        end
        if (REPEAT_EN == 0) begin
            press_d = rise_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            phase_q <= '0;
            level_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            press_q <= '0;
            for (int i = 0; i < N; i++) begin
                cnt_q[i]  <= '0;
                hcnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= in;
            sync2_q <= sync1_q;
            phase_q <= phase_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            press_q <= press_d;
            for (int i = 0; i < N; i++) begin
                cnt_q[i]  <= cnt_d[i];
                hcnt_q[i] <= hcnt_d[i];
            end
        end
    end

    assign level = level_q;
    assign rise  = rise_q;
    assign fall  = fall_q;
    assign press = press_q;

endmodule
`default_nettype wire

// File: tb/tb_debounce_multi.sv
`default_nettype none
// ============================================================================
//  Module      : tb_debounce_multi
//  Description : Scoreboard bench for debounce_multi; two instances (repeat
//                enabled / slow tick, and repeat disabled / tick every clk).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_debounce_multi;

    localparam int C_HOLD = 10;
    localparam int C_RPT  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_a, tick_b;
    logic [3:0] in_a, in_b;
    logic [3:0] lvl_a, rise_a, fall_a, press_a;
    logic [3:0] lvl_b, rise_b, fall_b, press_b;

    always #5 clk = ~clk;

    debounce_multi #(
        .N(4), .STABLE_TICKS(4), .REPEAT_EN(1), .HOLD_TICKS(10), .REPEAT_TICKS(3)
    ) u_dut_a (
        .clk(clk), .reset(rst), .tick(tick_a), .in(in_a),
        .level(lvl_a), .rise(rise_a), .fall(fall_a), .press(press_a)
    );

    debounce_multi #(
        .N(4), .STABLE_TICKS(1), .REPEAT_EN(0), .HOLD_TICKS(10), .REPEAT_TICKS(3)
    ) u_dut_b (
        .clk(clk), .reset(rst), .tick(tick_b), .in(in_b),
        .level(lvl_b), .rise(rise_b), .fall(fall_b), .press(press_b)
    );

    // Reference model: input seen two edges late, level commits once the
    // sampled value has differed for STABLE consecutive ticks; presses at
    // HOLD ticks after rise and every REPEAT ticks beyond that.
    int         stab [2] = '{4, 1};
    int         ren  [2] = '{1, 0};
    logic [3:0] h1   [2];
    logic [3:0] h2   [2];
    logic [3:0] mlvl [2];
    int         run  [2][4];
    int         held [2][4];

    logic [15:0] q_a [$];
    logic [15:0] q_b [$];
    logic [15:0] e_a, e_b;

    int checks = 0;
    int errors = 0;

    task automatic model_step(input int k, input logic r, input logic tk,
                              input logic [3:0] din, output logic [15:0] o);
        logic [3:0] samp, ri, fa, pr;
        ri = '0; fa = '0; pr = '0;
        if (r) begin
            h1[k] = '0; h2[k] = '0; mlvl[k] = '0;
            for (int c = 0; c < 4; c++) begin
                run[k][c]  = 0;
                held[k][c] = 0;
            end
        end else begin
            samp  = h2[k];
            h2[k] = h1[k];
            h1[k] = din;
            if (tk) begin
                for (int c = 0; c < 4; c++) begin
                    if (samp[c] != mlvl[k][c]) begin
                        run[k][c]++;
                        if (run[k][c] == stab[k]) begin
                            mlvl[k][c] = samp[c];
                            run[k][c]  = 0;
                            ri[c] = samp[c];
                            fa[c] = ~samp[c];
                        end
                    end else begin
                        run[k][c] = 0;
                    end
                    if (ri[c]) begin
                        held[k][c] = 0;
                        pr[c] = 1'b1;
                    end else if (mlvl[k][c]) begin
                        held[k][c]++;
                        if (held[k][c] == C_HOLD ||
                            (held[k][c] > C_HOLD && (held[k][c] - C_HOLD) % C_RPT == 0))
                            pr[c] = 1'b1;
                    end
                end
            end
            if (ren[k] == 0) pr = ri;
        end
        o = {mlvl[k], ri, fa, pr};
    endtask

    always @(posedge clk) begin
        model_step(0, rst, tick_a, in_a, e_a);
        q_a.push_back(e_a);
        model_step(1, rst, tick_b, in_b, e_b);
        q_b.push_back(e_b);
    end

    // Monitor: every clock the DUT presents level/rise/fall/press.
    logic [15:0] exp_v;
    always @(posedge clk) begin
        #1;
        checks++;
        if (q_a.size() == 0) begin
            errors++;
            $display("FAIL inst_a: scoreboard empty at %0t", $time);
        end else begin
            exp_v = q_a.pop_front();
            if ({lvl_a, rise_a, fall_a, press_a} !== exp_v) begin
                errors++;
                $display("FAIL inst_a @%0t: got lvl/rise/fall/press=%h expected %h",
                         $time, {lvl_a, rise_a, fall_a, press_a}, exp_v);
            end
        end
        checks++;
        if (q_b.size() == 0) begin
            errors++;
            $display("FAIL inst_b: scoreboard empty at %0t", $time);
        end else begin
            exp_v = q_b.pop_front();
            if ({lvl_b, rise_b, fall_b, press_b} !== exp_v) begin
                errors++;
                $display("FAIL inst_b @%0t: got lvl/rise/fall/press=%h expected %h",
                         $time, {lvl_b, rise_b, fall_b, press_b}, exp_v);
            end
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Background stimulus: divided tick for A; B toggles in[0] every 3 clk.
    initial begin
        int tc = 0;
        int bc = 0;
        tick_a = 1'b0;
        tick_b = 1'b1;
        in_b   = '0;
        forever begin
            @(negedge clk);
            tick_a = (tc == 3);
            tc = (tc + 1) % 4;
            bc++;
            if (bc % 3 == 0) in_b[0] = ~in_b[0];
            if ($urandom_range(0, 3) == 0) in_b[3:1] = 3'($urandom_range(0, 7));
        end
    end

    initial begin
        rst  = 1'b1;
        in_a = 4'hF;
        wait_clks(3);
        rst = 1'b0;
        wait_clks(40);
        // short glitch on channel 1
        in_a = 4'h0;     wait_clks(40);
        in_a = 4'b0010;  wait_clks(12);
        in_a = 4'h0;     wait_clks(40);
        // long hold on channel 2 for auto-repeat
        in_a = 4'b0100;  wait_clks(110);
        in_a = 4'h0;     wait_clks(40);
        // simultaneous rise on 0/3 with fall on 1
        in_a = 4'b0010;  wait_clks(40);
        in_a = 4'b1001;  wait_clks(40);
        in_a = 4'h0;     wait_clks(40);
        // reset mid-hold with input still asserted
        in_a = 4'b0001;  wait_clks(48);
        rst = 1'b1;      wait_clks(1);
        rst = 1'b0;      wait_clks(120);
        // randomized segments, including short glitches
        repeat (150) begin
            in_a = 4'($urandom_range(0, 15));
            wait_clks($urandom_range(1, 24));
        end
        in_a = 4'h0;
        wait_clks(40);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
